// File: rtl/pe_weight_loader.sv
// Serial weight loader for the PE array: collects NUM_PE signed weights in a shadow
// buffer and commits them to all lanes at once on swap_en. Optional: WLOAD_PERF_EN.
module pe_weight_loader #(
  parameter int WEIGHT_BW = 8,
  parameter int NUM_PE    = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        w_valid,
  output logic                        w_ready,
  input  logic [WEIGHT_BW-1:0]        w_data,
  input  logic                        swap_en,
  input  logic                        flush,
  output logic [NUM_PE*WEIGHT_BW-1:0] weight_bus,
  output logic                        weight_reload,
  output logic                        busy
`ifdef WLOAD_PERF_EN
  ,
  output logic [15:0]                 reload_count
`endif
);

  localparam int                CNT_W     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(NUM_PE - 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_WAIT_SWAP,
    S_RELOAD
  } state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [CNT_W-1:0]              r_cnt;
  logic [CNT_W-1:0]              w_cnt_nxt;
  logic                          w_accept;
  logic                          w_commit;
  logic                          r_reload;
  logic [WEIGHT_BW-1:0]          r_shadow [NUM_PE];
  logic [NUM_PE*WEIGHT_BW-1:0]   w_shadow_flat;
  logic [NUM_PE*WEIGHT_BW-1:0]   r_weight_bus;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    unique case (r_state)
      S_FILL: begin
        w_ready = 1'b1;
        // flush wins over a beat offered in the same cycle; that beat is dropped.
        if (flush) begin
          w_cnt_nxt = '0;
        end else if (w_valid) begin
          w_accept = 1'b1;
          if (r_cnt == LAST_LANE) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_WAIT_SWAP;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_WAIT_SWAP: begin
        if (flush) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_FILL;
        end else if (swap_en) begin
          w_commit    = 1'b1;
          w_state_nxt = S_RELOAD;
        end
      end
      S_RELOAD: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_FILL;
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_FILL;
      end
    endcase
  end

  always_comb begin
    w_shadow_flat = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      w_shadow_flat[i*WEIGHT_BW +: WEIGHT_BW] = r_shadow[i];
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_FILL;
      r_cnt        <= '0;
      r_reload     <= 1'b0;
      r_weight_bus <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_reload <= (w_state_nxt == S_RELOAD);
      if (w_commit) begin
        r_weight_bus <= w_shadow_flat;
      end
    end
  end

  // NOTE: the shadow buffer has no reset; its contents are only observed after a
  // full set has been written, so resetting it would only cost flops.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_shadow[r_cnt] <= w_data;
    end
  end

  assign weight_bus    = r_weight_bus;
  assign weight_reload = r_reload;
  assign busy          = (r_state != S_FILL) || (r_cnt != '0);

`ifdef WLOAD_PERF_EN
  logic [15:0] r_reload_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_reload_count <= '0;
    end else if (r_state == S_RELOAD) begin
      r_reload_count <= r_reload_count + 16'd1;
    end
  end

  assign reload_count = r_reload_count;
`endif

endmodule

// File: tb/tb_pe_weight_loader.sv
// Scoreboard bench for pe_weight_loader: a queue-based reference model predicts each
// committed weight set; a monitor compares it whenever weight_reload fires.
module tb_pe_weight_loader;

  localparam int W  = 8;
  localparam int NP = 4;
  localparam int BW = NP * W;

  logic          clk = 1'b0;
  logic          rstn;
  logic          w_valid;
  logic          w_ready;
  logic [W-1:0]  w_data;
  logic          swap_en;
  logic          flush;
  logic [BW-1:0] weight_bus;
  logic          weight_reload;
  logic          busy;
`ifdef WLOAD_PERF_EN
  logic [15:0]   reload_count;
  int unsigned   m_rcount;
`endif

  pe_weight_loader #(.WEIGHT_BW(W), .NUM_PE(NP)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .w_data        (w_data),
    .swap_en       (swap_en),
    .flush         (flush),
    .weight_bus    (weight_bus),
    .weight_reload (weight_reload),
    .busy          (busy)
`ifdef WLOAD_PERF_EN
    ,
    .reload_count  (reload_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: beats collected so far, the committed bus, and whether the
  // cycle after a commit is the reload strobe.
  logic [W-1:0]  m_q[$];
  logic [BW-1:0] m_bus;
  bit            m_reload;
  logic [BW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] pack_set();
    logic [BW-1:0] v = '0;
    for (int i = 0; i < NP; i++) v[i*W +: W] = m_q[i];
    return v;
  endfunction

  function automatic bit m_ready();
    return !m_reload && (m_q.size() < NP);
  endfunction

  function automatic bit m_busy();
    return m_reload || (m_q.size() != 0);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_bus    = '0;
    m_reload = 1'b0;
`ifdef WLOAD_PERF_EN
    m_rcount = 0;
`endif
  endtask

  task automatic model_update(input bit v, input logic [W-1:0] d, input bit s, input bit f);
    if (m_reload) begin
      m_reload = 1'b0;
`ifdef WLOAD_PERF_EN
      m_rcount++;
`endif
    end else if (m_q.size() == NP) begin
      if (f) begin
        m_q.delete();
      end else if (s) begin
        m_bus = pack_set();
        exp_q.push_back(m_bus);
        m_q.delete();
        m_reload = 1'b1;
      end
    end else begin
      if (f) m_q.delete();
      else if (v) m_q.push_back(d);
    end
  endtask

  task automatic check_outputs();
    check("w_ready", w_ready, m_ready());
    check("busy", busy, m_busy());
    check("weight_reload", weight_reload, m_reload);
    check("weight_bus", weight_bus, m_bus);
`ifdef WLOAD_PERF_EN
    check("reload_count", reload_count, 64'(m_rcount & 32'hFFFF));
`endif
  endtask

  // One clock cycle: check at the falling edge, drive, then advance the model at the rising edge.
  task automatic step(input bit v, input logic [W-1:0] d, input bit s, input bit f);
    @(negedge clk);
    check_outputs();
    w_valid = v;
    w_data  = d;
    swap_en = s;
    flush   = f;
    @(posedge clk);
    model_update(v, d, s, f);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NP; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
  endtask

  // Monitor: each reload strobe must match the oldest predicted commit.
  always @(negedge clk) begin
    if (rstn === 1'b1 && weight_reload === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("reload_unexpected", weight_reload, 1'b0);
      end else begin
        check("reload_bus", weight_bus, exp_q.pop_front());
      end
    end
  end

  initial begin
    rstn    = 1'b0;
    w_valid = 1'b0;
    w_data  = '0;
    swap_en = 1'b0;
    flush   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Back-to-back signed beats, then a one-cycle swap.
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 8'h7F, 1'b0, 1'b0);
    step(1'b1, 8'h80, 1'b0, 1'b0);
    #1 check("t1_ready_after_last", w_ready, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    #1 check("t1_reload_latency", weight_reload, 1'b1);
    check("t1_bus", weight_bus, 32'h807FFF01);
    check("t1_ready_in_reload", w_ready, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    #1 check("t1_reload_one_cycle", weight_reload, 1'b0);
    check("t1_ready_refill", w_ready, 1'b1);

    // Full set held without swap while the source keeps offering beats.
    fill_random();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, W'($urandom), 1'b0, 1'b0);
      #1 check("t2_stall", w_ready, 1'b0);
      check("t2_busy", busy, 1'b1);
      check("t2_bus_hold", weight_bus, 32'h807FFF01);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    #1 check("t2_reload", weight_reload, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Partial set discarded by flush.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    #1 check("t3_flush_busy", busy, 1'b0);
    step(1'b1, 8'hA0, 1'b0, 1'b0);
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hA2, 1'b0, 1'b0);
    step(1'b1, 8'hA3, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    #1 check("t3_bus", weight_bus, 32'hA3A2A1A0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // flush beats swap_en in WAIT_SWAP.
    fill_random();
    step(1'b0, 8'h00, 1'b1, 1'b1);
    #1 check("t4_no_reload", weight_reload, 1'b0);
    check("t4_busy", busy, 1'b0);
    check("t4_ready", w_ready, 1'b1);
    check("t4_bus_kept", weight_bus, 32'hA3A2A1A0);

    // Asynchronous reset mid-fill.
    for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
    w_valid = 1'b0;
    #2 rstn = 1'b0;
    #1 check("t5_rst_bus", weight_bus, '0);
    check("t5_rst_reload", weight_reload, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    #2 rstn = 1'b1;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    step(1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hE7, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    #1 check("t5_bus", weight_bus, 32'hE700C35A);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 9) < 7), W'($urandom),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
    end
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
